// File: rtl/ram_burst_reader.sv
// Burst read engine: streams len sequential words from a 1-cycle block RAM
// as a valid/ready stream with a last marker. The RAM output register acts
// as the first pipeline stage, so bursts run at one word per clock.
module ram_burst_reader #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [ASIZE:0]   len,
  output logic             busy,
  output logic             done,
  output logic [ASIZE-1:0] ram_addr,
  output logic             ram_en,
  input  logic [DSIZE-1:0] ram_dout,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int unsigned LW = ASIZE + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LW-1:0]   issue_left;
  logic [LW-1:0]   out_left;
  logic            s1_v;
  logic            advance;
  logic            accept;
  logic            capture;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, pipeline handshakes and the RAM read enable.
  // ram_en depends combinationally on m_ready so a full pipe can refill
  // in the same cycle the consumer drains it.
  always_comb begin
    state_nxt = state;
    advance   = s1_v & (~m_valid | m_ready);
    accept    = m_valid & m_ready;
    capture   = (state == IDLE) & start;
    ram_en    = (state == READ) & (issue_left != LW'(0)) & (~s1_v | advance);
    case (state)
      IDLE:    if (start) state_nxt = (len == LW'(0)) ? FINISH : READ;
      READ:    if (accept & m_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status flags derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == READ);
      done <= (state_nxt == FINISH);
    end
  end

  // Issue side: read pointer, words left to request, stage-1 occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      issue_left <= '0;
      s1_v       <= 1'b0;
    end else begin
      if (capture) begin
        ram_addr   <= base_addr;
        issue_left <= len;
      end else if (ram_en) begin
        ram_addr   <= ram_addr + ASIZE'(1);
        issue_left <= issue_left - LW'(1);
      end
      if (ram_en)       s1_v <= 1'b1;
      else if (advance) s1_v <= 1'b0;
    end
  end

  // Output stage: moves the RAM word into the stream register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_left <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      if (capture)      out_left <= len;
      else if (advance) out_left <= out_left - LW'(1);
      if (advance) begin
        m_data  <= ram_dout;
        m_valid <= 1'b1;
        m_last  <= (out_left == LW'(1));
      end else if (accept) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
